// File: rtl/vdg_address_counter_if.sv
// VDG address counter bus: fetch strobe, sync levels, SAM mode/offset in,
// display address and wrap pulse out.
interface vdg_address_counter_if;
  logic        ADV;
  logic        HS_n;
  logic        FS_n;
  logic [2:0]  V;
  logic [6:0]  F;
  logic [15:0] B;
  logic        B_WRAP;

  modport master (
    output ADV, HS_n, FS_n, V, F,
    input  B, B_WRAP
  );

  modport slave (
    input  ADV, HS_n, FS_n, V, F,
    output B, B_WRAP
  );
endinterface

// File: rtl/vdg_address_counter.sv
// SAM video address counter: B[3:0] -> X divider -> B[4] -> Y divider -> B[15:5].
// Column reset on HS falling edge, offset reload on FS falling edge.
// Optional macro VDG_SHADOW_EN: mode V is latched on the FS falling edge
// instead of being used live.
module vdg_address_counter (
  input  logic                  CLK,
  input  logic                  RST,
  vdg_address_counter_if.slave  bus
);

  logic [15:0] b_q, b_nxt;
  logic [1:0]  xcnt_q, xcnt_nxt;
  logic [3:0]  ycnt_q, ycnt_nxt;
  logic        wrap_q, wrap_nxt;
  logic        hs_prev_q, fs_prev_q;
  logic        hs_edge, fs_edge;
  logic        x_carry, y_carry;
  logic [2:0]  v_eff;
  logic [1:0]  xlim;
  logic [3:0]  ylim;

  assign hs_edge = hs_prev_q & ~bus.HS_n;
  assign fs_edge = fs_prev_q & ~bus.FS_n;

`ifdef VDG_SHADOW_EN
  // F is only consumed at the FS edge, where the new value is loaded
  // straight into B[15:9]; only V needs holding for the rest of the field.
  logic [2:0] v_sh_q;

  // Capture mode on field sync so mid-field writes wait for the next field
  always_ff @(posedge CLK) begin
    if (RST) begin
      v_sh_q <= '0;
    end else if (fs_edge) begin
      v_sh_q <= bus.V;
    end
  end

  assign v_eff = v_sh_q;
`else
  assign v_eff = bus.V;
`endif

  // Divisor limits (div-1) for the current mode
  always_comb begin
    xlim = 2'd0;
    ylim = 4'd0;
    case (v_eff)
      3'b000:  ylim = 4'd11;
      3'b001:  xlim = 2'd2;
      3'b010:  ylim = 4'd2;
      3'b011:  xlim = 2'd1;
      3'b100:  ylim = 4'd1;
      default: begin
        xlim = 2'd0;
        ylim = 4'd0;
      end
    endcase
  end

  // Next address: FS edge beats HS edge beats ADV; losers are dropped
  always_comb begin
    b_nxt    = b_q;
    xcnt_nxt = xcnt_q;
    ycnt_nxt = ycnt_q;
    wrap_nxt = 1'b0;
    x_carry  = 1'b0;
    y_carry  = 1'b0;
    if (fs_edge) begin
      b_nxt    = {bus.F, 9'd0};
      xcnt_nxt = '0;
      ycnt_nxt = '0;
    end else if (hs_edge) begin
      b_nxt[3:0] = '0;
      xcnt_nxt   = '0;
    end else if (bus.ADV) begin
      b_nxt[3:0] = b_q[3:0] + 4'd1;
      if (b_q[3:0] == 4'hF) begin
        // ">=" lets a counter stranded above a new, smaller limit wrap cleanly
        if (xcnt_q >= xlim) begin
          xcnt_nxt = '0;
          x_carry  = 1'b1;
        end else begin
          xcnt_nxt = xcnt_q + 2'd1;
        end
      end
      if (x_carry) begin
        b_nxt[4] = ~b_q[4];
        if (b_q[4]) begin
          if (ycnt_q >= ylim) begin
            ycnt_nxt = '0;
            y_carry  = 1'b1;
          end else begin
            ycnt_nxt = ycnt_q + 4'd1;
          end
        end
      end
      if (y_carry) begin
        b_nxt[15:5] = b_q[15:5] + 11'd1;
        wrap_nxt    = &b_q[15:5];
      end
    end
  end

  // Register address, dividers, wrap pulse and sync history
  always_ff @(posedge CLK) begin
    if (RST) begin
      b_q       <= '0;
      xcnt_q    <= '0;
      ycnt_q    <= '0;
      wrap_q    <= 1'b0;
      hs_prev_q <= 1'b1;
      fs_prev_q <= 1'b1;
    end else begin
      b_q       <= b_nxt;
      xcnt_q    <= xcnt_nxt;
      ycnt_q    <= ycnt_nxt;
      wrap_q    <= wrap_nxt;
      hs_prev_q <= bus.HS_n;
      fs_prev_q <= bus.FS_n;
    end
  end

  assign bus.B      = b_q;
  assign bus.B_WRAP = wrap_q;

endmodule

// File: tb/tb_vdg_address_counter.sv
// Directed bench for vdg_address_counter; expectations hand-computed.
module tb_vdg_address_counter;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  vdg_address_counter_if bus ();

  vdg_address_counter dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic adv(input int unsigned n);
    bus.ADV = 1'b1;
    repeat (n) tick();
    bus.ADV = 1'b0;
  endtask

  task automatic fs_pulse(input logic [6:0] f, input logic [15:0] exp);
    bus.F    = f;
    bus.FS_n = 1'b0;
    tick();
    check("fs_load", bus.B, exp);
    check("fs_nowrap", {15'd0, bus.B_WRAP}, 16'h0000);
    bus.FS_n = 1'b1;
    tick();
  endtask

  initial begin
    rst      = 1'b1;
    bus.ADV  = 1'b1;
    bus.HS_n = 1'b0;
    bus.FS_n = 1'b0;
    bus.V    = 3'd0;
    bus.F    = 7'd0;
    repeat (2) tick();
    check("rst_b", bus.B, 16'h0000);
    rst      = 1'b0;
    bus.ADV  = 1'b0;
    bus.HS_n = 1'b1;
    bus.FS_n = 1'b1;
    tick();
    check("post_rst_b", bus.B, 16'h0000);
    check("post_rst_wrap", {15'd0, bus.B_WRAP}, 16'h0000);

    // Mode 0: X1 Y12
    bus.V = 3'b000;
    fs_pulse(7'h02, 16'h0400);
    adv(16);
    check("m0_16", bus.B, 16'h0410);
    adv(16);
    check("m0_32", bus.B, 16'h0400);
    adv(352);
    check("m0_384", bus.B, 16'h0420);

    // Mode 1: X3 Y1
    bus.V = 3'b001;
    fs_pulse(7'h02, 16'h0400);
    adv(16);
    check("m1_16", bus.B, 16'h0400);
    adv(32);
    check("m1_48", bus.B, 16'h0410);
    adv(48);
    check("m1_96", bus.B, 16'h0420);

    // Mode 5: HS column reset and priority
    bus.V = 3'b101;
    fs_pulse(7'h02, 16'h0400);
    adv(5);
    check("m5_5", bus.B, 16'h0405);
    bus.HS_n = 1'b0;
    tick();
    check("hs_reset", bus.B, 16'h0400);
    bus.HS_n = 1'b1;
    tick();
    adv(21);
    check("m5_21", bus.B, 16'h0415);
    bus.HS_n = 1'b0;
    bus.ADV  = 1'b1;
    tick();
    check("hs_over_adv", bus.B, 16'h0410);
    bus.HS_n = 1'b1;
    bus.ADV  = 1'b0;
    tick();
    bus.F    = 7'h03;
    bus.HS_n = 1'b0;
    bus.FS_n = 1'b0;
    bus.ADV  = 1'b1;
    tick();
    check("fs_over_all", bus.B, 16'h0600);
    tick();
    check("sync_level_no_edge", bus.B, 16'h0601);
    bus.HS_n = 1'b1;
    bus.FS_n = 1'b1;
    bus.ADV  = 1'b0;
    tick();

    // Mode 7: full wrap
    bus.V = 3'b111;
    fs_pulse(7'h7F, 16'hFE00);
    adv(511);
    check("m7_ffff", bus.B, 16'hFFFF);
    check("m7_prewrap", {15'd0, bus.B_WRAP}, 16'h0000);
    adv(1);
    check("wrap_b", bus.B, 16'h0000);
    check("wrap_pulse", {15'd0, bus.B_WRAP}, 16'h0001);
    adv(1);
    check("after_wrap_b", bus.B, 16'h0001);
    check("after_wrap_pulse", {15'd0, bus.B_WRAP}, 16'h0000);
    fs_pulse(7'h00, 16'h0000);

    // Reset mid-line with ADV held
    adv(7);
    rst     = 1'b1;
    bus.ADV = 1'b1;
    tick();
    check("rst_mid", bus.B, 16'h0000);
    rst = 1'b0;
    tick();
    check("rst_resume", bus.B, 16'h0001);
    bus.ADV = 1'b0;
    tick();

    // Mid-field mode write: live vs shadowed
    bus.V = 3'b101;
    fs_pulse(7'h02, 16'h0400);
    bus.V = 3'b000;
    adv(32);
`ifdef VDG_SHADOW_EN
    check("midfield_v", bus.B, 16'h0420);
`else
    check("midfield_v", bus.B, 16'h0400);
`endif
    fs_pulse(7'h02, 16'h0400);
    adv(32);
    check("nextfield_y12", bus.B, 16'h0400);
    adv(128);
    check("y12_cnt5", bus.B, 16'h0400);
    // Y counter now 5; Y2 limit is 1, so the next carry wraps
    bus.V = 3'b100;
    adv(32);
`ifdef VDG_SHADOW_EN
    check("limit_drop", bus.B, 16'h0400);
`else
    check("limit_drop", bus.B, 16'h0420);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
